// File: rtl/mem_responder.sv
// Word-addressed SRAM responder for the load/store port.
// One request in flight, programmable wait cycles before the response.
module mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_wen;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_wstrb;

  logic [31:0] mem [DEPTH];

  logic          a_wen;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_wstrb;
  logic [31:0]   off;
  logic [AW-1:0] a_idx;
  logic          a_in;
  logic          enter_resp;
  logic          unused_off;

  // Zero-latency access uses the live request; otherwise the latched copy
  always_comb begin
    a_wen   = l_wen;
    a_addr  = l_addr;
    a_wdata = l_wdata;
    a_wstrb = l_wstrb;
    if (state == IDLE) begin
      a_wen   = req_wen;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
    end
    off   = a_addr - BASE;
    a_idx = off[AW+1:2];
    a_in  = ({1'b0, a_addr} >= {1'b0, BASE}) &&
            ({1'b0, a_addr} < LIMIT);
    enter_resp = 1'b0;
    if (state == IDLE && req_valid && req_ready && ZERO_LAT)
      enter_resp = 1'b1;
    if (state == WAIT && cnt == 4'd0)
      enter_resp = 1'b1;
  end

  assign unused_off = ^{off[31:AW+2], off[1:0]};

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && a_wen && a_in) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wstrb[i])
          mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            l_wen     <= req_wen;
            l_addr    <= req_addr;
            l_wdata   <= req_wdata;
            l_wstrb   <= req_wstrb;
            req_ready <= 1'b0;
            cnt       <= LAT_M1;
            state     <= WAIT;
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Later assignment overrides the WAIT/IDLE defaults above
      if (enter_resp) begin
        state     <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= !a_in;
        rsp_rdata <= (a_wen || !a_in) ? 32'd0 : mem[a_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 1, 0 and 15.
// Slot 0: LATENCY=1, slot 1: LATENCY=0, slot 2: LATENCY=15.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] req_valid, req_ready, req_wen;
  logic [2:0] rsp_valid, rsp_ready, rsp_err;
  logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0][3:0]  req_wstrb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  mem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .req_wstrb(req_wstrb[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns after the accepting edge (+#1)
  task automatic accept(input int d, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic rrdy,
                        output int acc);
    logic got;
    got = 1'b0;
    acc = -1;
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = strb;
    rsp_ready[d] = rrdy;
    for (int i = 0; i < 40; i++) begin
      if (req_ready[d]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    req_valid[d] = 1'b0;
  endtask

  // Counts negedges after acceptance until rsp_valid is seen
  task automatic wait_rsp(input int d, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat_exp [3] = '{2, 1, 16};

  task automatic do_rw(input int d, input string tag, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_d,
                       input logic exp_e, output int acc);
    int lat;
    @(negedge clk);
    accept(d, wen, addr, wdata, strb, 1'b1, acc);
    wait_rsp(d, lat);
    check({tag, ".lat"}, lat, lat_exp[d]);
    check({tag, ".data"}, rsp_rdata[d], exp_d);
    check({tag, ".err"}, {31'd0, rsp_err[d]}, {31'd0, exp_e});
  endtask

  initial begin
    int a0, a1, a2, lat;
    logic seen;
    rst = 1'b1;
    req_valid = '0;
    req_wen = '0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst.req_ready", {31'd0, req_ready[d]}, 32'd1);
      check("rst.rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check("rst.rsp_err", {31'd0, rsp_err[d]}, 32'd0);
      check("rst.rsp_rdata", rsp_rdata[d], 32'd0);
    end
    rst = 1'b0;

    do_rw(0, "wr10", 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, a0);
    do_rw(0, "rd10", 0, 32'h8000_0010, 0, 4'h0, 32'hDEAD_BEEF, 0, a0);
    do_rw(0, "wr10h", 1, 32'h8000_0010, 32'h0000_1122, 4'b0011, 0, 0, a0);
    do_rw(0, "rd10h", 0, 32'h8000_0010, 0, 4'h0, 32'hDEAD_1122, 0, a0);
    do_rw(0, "wrs0", 1, 32'h8000_0010, 32'h5555_5555, 4'h0, 0, 0, a0);
    do_rw(0, "rds0", 0, 32'h8000_0010, 0, 4'h0, 32'hDEAD_1122, 0, a0);

    // Response stalled by the requester; a new request must be ignored
    @(negedge clk);
    accept(0, 0, 32'h8000_0010, 0, 4'h0, 1'b0, a0);
    wait_rsp(0, lat);
    check("stall.lat", lat, 2);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_wdata[0] = 32'h0BAD_0BAD;
    req_wstrb[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall.valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("stall.data", rsp_rdata[0], 32'hDEAD_1122);
      check("stall.ready", {31'd0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("hs.valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("hs.ready", {31'd0, req_ready[0]}, 32'd1);
    do_rw(0, "rd10i", 0, 32'h8000_0010, 0, 4'h0, 32'hDEAD_1122, 0, a0);

    do_rw(0, "rdlo", 0, 32'h7FFF_FFFC, 0, 4'h0, 0, 1, a0);
    do_rw(0, "rdhi", 0, 32'h8000_1000, 0, 4'h0, 0, 1, a0);
    do_rw(0, "wr0", 1, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 0, 0, a0);
    do_rw(0, "wrhi", 1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 1, a0);
    do_rw(0, "rd0", 0, 32'h8000_0000, 0, 4'h0, 32'hA5A5_A5A5, 0, a0);
    do_rw(0, "wrtop", 1, 32'h8000_0FFF, 32'h1234_5678, 4'hF, 0, 0, a0);
    do_rw(0, "rdtop", 0, 32'h8000_0FFC, 0, 4'h0, 32'h1234_5678, 0, a0);

    // LATENCY=0: responses one cycle out, acceptances two apart
    do_rw(1, "z.wr", 1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, a0);
    do_rw(1, "z.rd1", 0, 32'h8000_0040, 0, 4'h0, 32'hCAFE_F00D, 0, a1);
    do_rw(1, "z.rd2", 0, 32'h8000_0040, 0, 4'h0, 32'hCAFE_F00D, 0, a2);
    check("z.gap1", a1 - a0, 2);
    check("z.gap2", a2 - a1, 2);

    // LATENCY=15: responses sixteen cycles out, acceptances 17 apart
    do_rw(2, "f.wr", 1, 32'h8000_0020, 32'h1111_1111, 4'hF, 0, 0, a0);
    do_rw(2, "f.rd1", 0, 32'h8000_0020, 0, 4'h0, 32'h1111_1111, 0, a1);
    do_rw(2, "f.rd2", 0, 32'h8000_0020, 0, 4'h0, 32'h1111_1111, 0, a2);
    check("f.gap1", a1 - a0, 17);
    check("f.gap2", a2 - a1, 17);

    // Reset while a write is still waiting drops it
    @(negedge clk);
    accept(2, 1, 32'h8000_0020, 32'h2222_2222, 4'hF, 1'b1, a0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw.ready", {31'd0, req_ready[2]}, 32'd1);
    check("rw.err", {31'd0, rsp_err[2]}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
    end
    check("rw.noresp", {31'd0, seen}, 32'd0);
    do_rw(2, "rw.rd", 0, 32'h8000_0020, 0, 4'h0, 32'h1111_1111, 0, a0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one read or write request at a time and returns one response.
- Uses a valid/ready request channel and a valid/ready response channel.
- Backs a word-addressed SRAM array mapped at BASE.
- Programmable access latency lets multi-cycle fetch/LSU logic be exercised against realistic memory timing.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, extra wait cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  write data.
- req_wstrb  input  4  byte enables for writes; bit i enables byte lane i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  read data; 0 for writes and for errors.
- rsp_err  output  1  address outside [BASE, BASE+4*DEPTH).

Behaviour:
- State machine states: IDLE, WAIT, RESP.
- Reset:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not cleared.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T, latch wen, addr, wdata and wstrb.
  - If LATENCY=0, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0; decrement the counter each cycle.
  - When counter==0, go to RESP.
- Array access happens on the edge that enters RESP, from the latched fields:
  - Read: rsp_rdata <= mem[idx].
  - Write: only lanes with wstrb=1 are updated; rsp_rdata <= 0.
  - idx = (addr-BASE)>>2, truncated to log2(DEPTH) bits.
- Resulting timing: rsp_valid first high in cycle T+1+LATENCY.
- Out-of-range address (addr<BASE or addr>=BASE+4*DEPTH):
  - No array write; rsp_rdata=0, rsp_err=1.
  - Response timing is identical to an in-range access.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready.
  - On that handshake: go to IDLE, clear rsp_valid, clear rsp_err.
- Throughput:
  - One outstanding request; at least one IDLE cycle between a response handshake and the next acceptance.
  - Maximum rate is one transaction per LATENCY+2 cycles.
- Requests presented while req_ready=0 are ignored; the requester must hold them until accepted.
- wstrb=0 on a write: legal; a normal response is returned and memory is unchanged.
- Read-after-write to the same word in the next transaction returns the newly written data.
- rst mid-transaction (WAIT or RESP):
  - Go to IDLE with all outputs at reset values; the pending response is dropped.
  - A write already committed on the RESP entry edge stays in the array; a write still in WAIT is discarded.
- Arithmetic:
  - Range check uses unsigned 32-bit compares, computed without overflow (BASE+4*DEPTH evaluated at 33 bits).
  - The counter is 4 bits wide.

Test Plan:
- LATENCY=1: after reset, check req_ready=1 and rsp_valid=0. Write 0xDEADBEEF to 0x8000_0010 with wstrb=4'hF (accept at T), hold rsp_ready=1 -> rsp_valid exactly in cycle T+2, rsp_err=0, rsp_rdata=0.
- Read 0x8000_0010 -> rsp_rdata=0xDEADBEEF. Then write 0x0000_1122 with wstrb=4'b0011 and read again -> 0xDEAD1122.
- Hold rsp_ready=0 for 5 cycles during a read -> rsp_valid stays 1, data stable, req_ready=0, and a new req_valid is ignored. Raise rsp_ready -> one-cycle handshake, back to IDLE, req_ready=1 next cycle.
- Read 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> rsp_err=1, rsp_rdata=0. A write to 0x8000_1000 does not alter word 0 (aliasing check).
- LATENCY=0 and LATENCY=15 builds: back-to-back reads with rsp_ready=1 -> responses at T+1 and T+16; acceptances spaced 2 and 17 cycles apart.
- Assert rst in WAIT of a write to 0x8000_0020 -> rsp_valid never rises; a later read of 0x8000_0020 returns the old value.
